// File: rtl/pipe_rx_fifo_ram.sv
// Simple dual-port storage for the receive FIFO: one synchronous write port and
// an asynchronous read port so the head word falls through without a cycle of latency.
module pipe_rx_fifo_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_rx_fifo.sv
// Receive buffer for a ready-less pipelined link: stores every arriving word and
// raises a registered stall early enough that words still in flight always fit.
module pipe_rx_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int PIPE_DEPTH = 2,
  parameter int BACK_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    s_data,
  input  logic                     s_valid,
  output logic                     s_stall,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int SLACK  = PIPE_DEPTH + BACK_DEPTH + 2;
  localparam int THRESH = DEPTH - SLACK;
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;

  generate
    if (THRESH < 1) begin : g_bad_thresh
      $error("pipe_rx_fifo: DEPTH too small for the round-trip slack (THRESH < 1)");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pipe_rx_fifo: DEPTH must be a power of two and at least 4");
    end
  endgenerate

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] count_reg;
  logic [PW-1:0] count_next;
  logic          stall_reg;
  logic          overflow_reg;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full  = (wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {AW{1'b0}}};
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign pop   = m_valid && m_ready;
  assign push  = s_valid && (!full || pop);
  assign drop  = s_valid && full && !pop;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + PW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      stall_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_next;
      // Stall looks at post-edge occupancy so it already covers this cycle's push.
      stall_reg <= (count_next >= PW'(THRESH));
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  pipe_rx_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_reg[AW-1:0]),
    .wdata (s_data),
    .raddr (rd_ptr_reg[AW-1:0]),
    .rdata (m_data)
  );

  assign m_valid  = !empty;
  assign count    = count_reg;
  assign s_stall  = stall_reg;
  assign overflow = overflow_reg;

endmodule
